// File: rtl/spi_master_scheduler_if.sv
// Bundle of client, spi_master stream and status signals around the scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface spi_master_scheduler_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned TRANSFER_WIDTH = 8,
  parameter int unsigned LEN_WIDTH      = 8
);
  localparam int unsigned GW = $clog2(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0]                req_valid;
  logic [NUM_REQUESTERS-1:0]                req_ready;
  logic [NUM_REQUESTERS*LEN_WIDTH-1:0]      req_wr_len;
  logic [NUM_REQUESTERS*LEN_WIDTH-1:0]      req_rd_len;
  logic [NUM_REQUESTERS*TRANSFER_WIDTH-1:0] tx_tdata;
  logic [NUM_REQUESTERS-1:0]                tx_tvalid;
  logic [NUM_REQUESTERS-1:0]                tx_tready;
  logic [TRANSFER_WIDTH-1:0]                rx_tdata;
  logic [NUM_REQUESTERS-1:0]                rx_tvalid;
  logic [NUM_REQUESTERS-1:0]                rx_tready;
  logic [TRANSFER_WIDTH-1:0]                spi_tx_tdata;
  logic                                     spi_tx_tvalid;
  logic                                     spi_tx_tready;
  logic [TRANSFER_WIDTH-1:0]                spi_rx_tdata;
  logic                                     spi_rx_tvalid;
  logic                                     spi_rx_tready;
  logic [NUM_REQUESTERS-1:0]                cs_n;
  logic [GW-1:0]                            grant;
  logic                                     busy;
  logic [NUM_REQUESTERS-1:0]                done;

  modport master (
    input  req_valid, req_wr_len, req_rd_len, tx_tdata, tx_tvalid, rx_tready,
           spi_tx_tready, spi_rx_tdata, spi_rx_tvalid,
    output req_ready, tx_tready, rx_tdata, rx_tvalid, spi_tx_tdata, spi_tx_tvalid,
           spi_rx_tready, cs_n, grant, busy, done
  );

  modport slave (
    output req_valid, req_wr_len, req_rd_len, tx_tdata, tx_tvalid, rx_tready,
           spi_tx_tready, spi_rx_tdata, spi_rx_tvalid,
    input  req_ready, tx_tready, rx_tdata, rx_tvalid, spi_tx_tdata, spi_tx_tvalid,
           spi_rx_tready, cs_n, grant, busy, done
  );
endinterface

// File: rtl/spi_master_scheduler.sv
// Round-robin scheduler sharing one spi_master between several clients.
// Each command is a cs_n-framed write phase followed by a read phase padded
// with FILL_BYTE; write-phase MISO words are dropped, read-phase words are
// steered to the owning client.
module spi_master_scheduler #(
  parameter int unsigned                NUM_REQUESTERS  = 4,
  parameter int unsigned                TRANSFER_WIDTH  = 8,
  parameter int unsigned                LEN_WIDTH       = 8,
  parameter logic [TRANSFER_WIDTH-1:0]  FILL_BYTE       = '1,
  parameter int unsigned                CS_SETUP_CYCLES = 2,
  parameter int unsigned                CS_HOLD_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  spi_master_scheduler_if.master bus
);
  localparam int unsigned N    = NUM_REQUESTERS;
  localparam int unsigned GW   = $clog2(N);
  localparam int unsigned CW   = LEN_WIDTH + 1;
  localparam int unsigned PMAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0] wr_len_q, wr_len_d;
  logic [CW-1:0]        total_q, total_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [PW-1:0]        phase_cnt_q, phase_cnt_d;
  logic [N-1:0]         cs_n_q, cs_n_d;
  logic [N-1:0]         req_ready_q, req_ready_d;

  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic [LEN_WIDTH-1:0] win_wr, win_rd;
  logic [CW-1:0]        win_total;

  logic [N-1:0]              tx_tready, rx_tvalid, done;
  logic                      spi_tx_tvalid, spi_rx_tready;
  logic [TRANSFER_WIDTH-1:0] spi_tx_tdata;
  logic                      tx_hs, rx_hs;

  // Round-robin pick: first requester after last_grant, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!win_found && bus.req_valid[(32'(last_grant_q) + i) % N]) begin
        win_found = 1'b1;
        win_idx   = GW'((32'(last_grant_q) + i) % N);
      end
    end
    win_wr    = bus.req_wr_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
    win_rd    = bus.req_rd_len[win_idx*LEN_WIDTH +: LEN_WIDTH];
    win_total = CW'(win_wr) + CW'(win_rd);
  end

  // Transaction FSM next state plus MOSI mux and MISO demux.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    wr_len_d      = wr_len_q;
    total_d       = total_q;
    tx_cnt_d      = tx_cnt_q;
    rx_cnt_d      = rx_cnt_q;
    phase_cnt_d   = phase_cnt_q;
    cs_n_d        = cs_n_q;
    req_ready_d   = '0;
    tx_tready     = '0;
    rx_tvalid     = '0;
    done          = '0;
    spi_tx_tvalid = 1'b0;
    spi_tx_tdata  = '0;
    spi_rx_tready = 1'b1;
    tx_hs         = 1'b0;
    rx_hs         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d              = win_idx;
          wr_len_d             = win_wr;
          total_d              = win_total;
          tx_cnt_d             = '0;
          rx_cnt_d             = '0;
          phase_cnt_d          = '0;
          req_ready_d[win_idx] = 1'b1;
          if (win_total != '0) cs_n_d[win_idx] = 1'b0;
          state_d              = S_SETUP;
        end
      end

      // Zero-length commands pass through SETUP for one cycle with cs_n
      // left high, so the req_ready pulse and done land on consecutive cycles.
      S_SETUP: begin
        if (total_q == '0) begin
          state_d = S_DONE;
        end else if (phase_cnt_q == PW'(CS_SETUP_CYCLES - 1)) begin
          phase_cnt_d = '0;
          state_d     = S_XFER;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end

      S_XFER: begin
        if (tx_cnt_q < {1'b0, wr_len_q}) begin
          spi_tx_tvalid      = bus.tx_tvalid[grant_q];
          spi_tx_tdata       = bus.tx_tdata[grant_q*TRANSFER_WIDTH +: TRANSFER_WIDTH];
          tx_tready[grant_q] = bus.spi_tx_tready;
        end else if (tx_cnt_q < total_q) begin
          spi_tx_tvalid = 1'b1;
          spi_tx_tdata  = FILL_BYTE;
        end
        tx_hs = spi_tx_tvalid && bus.spi_tx_tready;

        if ((rx_cnt_q >= {1'b0, wr_len_q}) && (rx_cnt_q < total_q)) begin
          rx_tvalid[grant_q] = bus.spi_rx_tvalid;
          spi_rx_tready      = bus.rx_tready[grant_q];
        end
        rx_hs = bus.spi_rx_tvalid && spi_rx_tready && (rx_cnt_q < total_q);

        if (tx_hs) tx_cnt_d = tx_cnt_q + 1'b1;
        if (rx_hs) rx_cnt_d = rx_cnt_q + 1'b1;
        // Leave on the edge of the final handshake so the hold count starts next cycle.
        if ((tx_cnt_d == total_q) && (rx_cnt_d == total_q)) begin
          phase_cnt_d = '0;
          state_d     = S_HOLD;
        end
      end

      S_HOLD: begin
        if (phase_cnt_q == PW'(CS_HOLD_CYCLES - 1)) begin
          cs_n_d  = '1;
          state_d = S_DONE;
        end else begin
          phase_cnt_d = phase_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        done[grant_q] = 1'b1;
        cs_n_d        = '1;
        last_grant_d  = grant_q;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered chip selects with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N - 1);
      wr_len_q     <= '0;
      total_q      <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      phase_cnt_q  <= '0;
      cs_n_q       <= '1;
      req_ready_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_len_q     <= wr_len_d;
      total_q      <= total_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      cs_n_q       <= cs_n_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.tx_tready     = tx_tready;
  assign bus.rx_tdata      = bus.spi_rx_tdata;
  assign bus.rx_tvalid     = rx_tvalid;
  assign bus.spi_tx_tdata  = spi_tx_tdata;
  assign bus.spi_tx_tvalid = spi_tx_tvalid;
  assign bus.spi_rx_tready = spi_rx_tready;
  assign bus.cs_n          = cs_n_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done;
endmodule
